frame_payload_buffer: RTL and testbench
=======================================

# frame_payload_buffer

Sits directly downstream of the frame aligner and consumes its byte stream, byte position and frame_detect indication. It extracts the 10 payload bytes of each legal 12-byte frame and tags each frame with its header type. Complete frames are stored in a small frame-slot FIFO and delivered to the consumer as a byte stream with valid/ready handshake and start/end-of-frame markers. Frames that are broken, arrive while not aligned, or arrive with no free slot are discarded whole.

## Interface
- FRAME_SLOTS, 2: number of frame buffers; power of two, at least 2.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_data  in  8  aligned byte stream, same cycle as the aligner's rx_data.
- fr_byte_position  in  4  aligner byte position.
- frame_detect  in  1  aligner lock indication.
- m_data  out  8  payload byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the byte.
- m_sof  out  1  first payload byte of a frame; qualified by m_valid.
- m_eof  out  1  tenth payload byte of a frame; qualified by m_valid.
- m_hdr_type  out  1  0 = header 0xAA/0xAF, 1 = header 0x55/0xBA; constant for the whole frame.
- drop_count  out  8  saturating count of complete frames dropped because no slot was free.

## Operation
- Arm: a cycle with fr_byte_position==0 and rx_data==0xAF or 0xBA arms capture and latches the header type (0xAF→0, 0xBA→1). A pos==0 cycle with any other byte disarms.
- Capture: the cycle after arming must have pos==1. Pos 1..10 carry payload bytes 0..9, written into the write slot at index pos-1.
- Break: while capturing, if pos is not the previous pos+1, the frame is aborted and its slot is not committed. If that cycle is itself a valid arm cycle, it re-arms.
- Commit: at pos==10, the frame is committed only if frame_detect==1 on that cycle and a slot was free at pos==1. Otherwise it is silently discarded (no-slot case increments drop_count, saturating at 255).
- Slot check happens at pos==1. If the FIFO is full, the whole frame is marked dropped, even if a slot frees mid-frame.
- Read: m_valid=1 whenever at least one committed slot exists. m_data, m_hdr_type and m_sof/m_eof come from the read slot and read index.
- A byte transfers on m_valid&&m_ready. After index 9 transfers, the slot is freed and the read index returns to 0.
- m_valid must not depend on m_ready. Data is held stable while m_valid && !m_ready.
- Commit and free in the same cycle: occupancy is unchanged. Both slot pointers wrap modulo FRAME_SLOTS.

## Timing
- Reset values: m_valid=0, m_sof=0, m_eof=0, m_data=0, m_hdr_type=0, drop_count=0. Pointers, occupancy and arm/capture state all clear.
- Reset mid-frame or mid-read discards everything.
- Commit latency: a frame whose pos==10 byte arrives in cycle N gives m_valid=1 with m_sof=1 in cycle N+1 (empty FIFO).
- Throughput: one byte per cycle. A 10-byte frame drains in 10 cycles with m_ready held high.
- Write-side FSM states: S_IDLE (disarmed), S_ARMED, S_CAPTURE, S_DROP (tracking positions of a no-slot frame so drop_count counts at pos==10).
  - S_IDLE/S_ARMED → S_ARMED on an arm cycle.
  - S_ARMED → S_CAPTURE or S_DROP on pos==1; otherwise → S_IDLE.
  - S_CAPTURE/S_DROP → S_IDLE at pos==10 or on break.

## Structure
- Shared package frame_pkg: HDR_LSB_A=0xAA, HDR_MSB_A=0xAF, HDR_LSB_B=0x55, HDR_MSB_B=0xBA, PAYLOAD_LEN=10, FRAME_LEN=12, write-FSM state enum.
- One sub-module: frame_slot_fifo. It holds FRAME_SLOTS×PAYLOAD_LEN byte storage, per-slot hdr_type, commit/free pointers and occupancy.
- The top contains the arm/capture FSM, the drop counter and the read-index logic.

## Test plan
- Lock the aligner with 4 frames (AA AF + bytes 01..0A), m_ready=1 → the 4th frame (frame_detect high at its pos 10) appears as 01..0A with hdr_type=0, sof on 01, eof on 0A. The first frames are discarded while frame_detect=0.
- Locked stream with 55 BA header → payload delivered with m_hdr_type=1 throughout the frame.
- m_ready=0 while 3 frames arrive (FRAME_SLOTS=2) → the first two are held, drop_count=1. Release m_ready → 20 bytes in order, then m_valid=0.
- Position sequence 0,1,2,3,0 (header lost mid-frame) → no commit, drop_count unchanged, m_valid stays 0.
- Commit of a new frame in the same cycle the last byte of a full slot is read → no drop, occupancy unchanged, next frame follows back-to-back.
- Assert reset during frame capture and during a read → all outputs are at reset values the next cycle, and the partial frame is never delivered.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants, write-side FSM states and header helpers for the frame payload buffer.
package frame_pkg;

    localparam logic [7:0] HDR_LSB_A = 8'hAA;
    localparam logic [7:0] HDR_MSB_A = 8'hAF;
    localparam logic [7:0] HDR_LSB_B = 8'h55;
    localparam logic [7:0] HDR_MSB_B = 8'hBA;

    localparam int PAYLOAD_LEN = 10;
    localparam int FRAME_LEN   = 12;

    localparam logic [3:0] POS_HDR   = 4'd0;
    localparam logic [3:0] POS_FIRST = 4'd1;
    localparam logic [3:0] POS_LAST  = 4'(PAYLOAD_LEN);
    localparam logic [3:0] IDX_LAST  = 4'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DROP
    } wr_state_t;

    // The aligner reports position 0 on the second header byte, so only that byte arms capture.
    function automatic logic is_arm_byte(input logic [7:0] b);
        return (b == HDR_MSB_A) || (b == HDR_MSB_B);
    endfunction

    function automatic logic hdr_type_of(input logic [7:0] b);
        return (b == HDR_MSB_B);
    endfunction

endpackage

// File: rtl/frame_slot_fifo.sv
// Frame-slot FIFO: payload storage per slot, header type per slot, commit/free pointers and occupancy.
module frame_slot_fifo
    import frame_pkg::*;
#(
    parameter int FRAME_SLOTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       commit_hdr,
    input  logic       free,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       rd_hdr,
    output logic       empty,
    output logic       full
);

    localparam int SLOT_W = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;

    logic [7:0]        mem      [FRAME_SLOTS][PAYLOAD_LEN];
    logic              slot_hdr [FRAME_SLOTS];
    logic [SLOT_W-1:0] wr_ptr;
    logic [SLOT_W-1:0] rd_ptr;
    logic [SLOT_W:0]   count;

    // Payload bytes land in the uncommitted write slot; nothing is visible until commit bumps occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr][wr_idx] <= wr_data;
        end
        if (commit) begin
            slot_hdr[wr_ptr] <= commit_hdr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + SLOT_W'(1);
            end
            if (free) begin
                rd_ptr <= rd_ptr + SLOT_W'(1);
            end
            case ({commit, free})
                2'b10:   count <= count + (SLOT_W + 1)'(1);
                2'b01:   count <= count - (SLOT_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr][rd_idx];
    assign rd_hdr  = slot_hdr[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (SLOT_W + 1)'(FRAME_SLOTS));

endmodule

// File: rtl/frame_payload_buffer.sv
// Extracts the 10 payload bytes of each aligned frame, buffers whole frames and streams them out.
module frame_payload_buffer
    import frame_pkg::*;
#(
    parameter int FRAME_SLOTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic [3:0] fr_byte_position,
    input  logic       frame_detect,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_eof,
    output logic       m_hdr_type,
    output logic [7:0] drop_count
);

    wr_state_t  state;
    wr_state_t  state_next;
    logic [3:0] pos_q;
    logic       hdr_q;
    logic       arm_cycle;
    logic       seq_ok;
    logic       at_first;
    logic       at_last;
    logic       wr_en;
    logic       commit;
    logic       drop_inc;
    logic       arm_take;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] rd_data;
    logic       rd_hdr;
    logic [3:0] rd_idx;
    logic       xfer;
    logic       free;

    assign arm_cycle = (fr_byte_position == POS_HDR) && is_arm_byte(rx_data);
    assign seq_ok    = (fr_byte_position == pos_q + 4'd1);
    assign at_first  = (fr_byte_position == POS_FIRST);
    assign at_last   = (fr_byte_position == POS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (arm_cycle) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (at_first)       state_next = fifo_full ? S_DROP : S_CAPTURE;
                else if (arm_cycle) state_next = S_ARMED;
                else                state_next = S_IDLE;
            end
            S_CAPTURE, S_DROP: begin
                if (!seq_ok)      state_next = arm_cycle ? S_ARMED : S_IDLE;
                else if (at_last) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A broken sequence aborts the frame; the same cycle may re-arm if it carries a valid header byte.
    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        drop_inc = 1'b0;
        arm_take = 1'b0;
        case (state)
            S_IDLE: begin
                arm_take = arm_cycle;
            end
            S_ARMED: begin
                if (at_first) wr_en    = !fifo_full;
                else          arm_take = arm_cycle;
            end
            S_CAPTURE: begin
                if (!seq_ok) begin
                    arm_take = arm_cycle;
                end else begin
                    wr_en  = 1'b1;
                    commit = at_last && frame_detect;
                end
            end
            S_DROP: begin
                if (!seq_ok) arm_take = arm_cycle;
                else         drop_inc = at_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
            hdr_q <= 1'b0;
        end else begin
            pos_q <= fr_byte_position;
            if (arm_take) begin
                hdr_q <= hdr_type_of(rx_data);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_inc && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    frame_slot_fifo #(
        .FRAME_SLOTS(FRAME_SLOTS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (fr_byte_position - 4'd1),
        .wr_data   (rx_data),
        .commit    (commit),
        .commit_hdr(hdr_q),
        .free      (free),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_hdr    (rd_hdr),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign xfer = m_valid && m_ready;
    assign free = xfer && (rd_idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx <= '0;
        end else if (xfer) begin
            rd_idx <= (rd_idx == IDX_LAST) ? 4'd0 : rd_idx + 4'd1;
        end
    end

    // Outputs are forced to zero while empty so uninitialised slot storage never leaks out.
    assign m_valid    = !fifo_empty;
    assign m_data     = m_valid ? rd_data : 8'h00;
    assign m_hdr_type = m_valid && rd_hdr;
    assign m_sof      = m_valid && (rd_idx == 4'd0);
    assign m_eof      = m_valid && (rd_idx == IDX_LAST);

endmodule

// File: tb/tb_frame_payload_buffer.sv
// Directed self-checking bench for frame_payload_buffer with FRAME_SLOTS=2.
module tb_frame_payload_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic [3:0] fr_byte_position;
    logic       frame_detect;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_sof;
    logic       m_eof;
    logic       m_hdr_type;
    logic [7:0] drop_count;

    int vectors     = 0;
    int miscompares = 0;

    frame_payload_buffer #(
        .FRAME_SLOTS(2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .fr_byte_position(fr_byte_position),
        .frame_detect    (frame_detect),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_sof           (m_sof),
        .m_eof           (m_eof),
        .m_hdr_type      (m_hdr_type),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] pos, input logic detect);
        rx_data          = data;
        fr_byte_position = pos;
        frame_detect     = detect;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(8'h00, 4'd11, 1'b1);
    endtask

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [7:0] d,
                               input logic sof, input logic eof, input logic hdr);
        checkValue({tag, ".valid"}, {7'd0, m_valid},    {7'd0, v});
        checkValue({tag, ".data"},  m_data,             d);
        checkValue({tag, ".sof"},   {7'd0, m_sof},      {7'd0, sof});
        checkValue({tag, ".eof"},   {7'd0, m_eof},      {7'd0, eof});
        checkValue({tag, ".hdr"},   {7'd0, m_hdr_type}, {7'd0, hdr});
    endtask

    task automatic checkDrop(input string tag, input logic [7:0] exp);
        checkValue({tag, ".drop"}, drop_count, exp);
    endtask

    task automatic sendFrame(input logic [7:0] msb, input logic [7:0] lsb,
                             input logic [7:0] base, input logic detect);
        applyStimulus(lsb, 4'd11, detect);
        applyStimulus(msb, 4'd0, detect);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(base + 8'(i), 4'(i + 1), detect);
        end
    endtask

    task automatic drainFrame(input string tag, input logic [7:0] base, input logic hdr);
        for (int i = 0; i < 10; i++) begin
            checkOutput(tag, 1'b1, base + 8'(i), (i == 0), (i == 9), hdr);
            idleCycle();
        end
    endtask

    initial begin
        reset            = 1'b1;
        rx_data          = 8'h00;
        fr_byte_position = 4'd0;
        frame_detect     = 1'b0;
        m_ready          = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkDrop("reset", 8'd0);
        reset = 1'b0;

        // Lock-up: frames without frame_detect are discarded, the fourth is delivered.
        for (int f = 0; f < 3; f++) begin
            sendFrame(8'hAF, 8'hAA, 8'h01, 1'b0);
            checkValue("unlocked.valid", {7'd0, m_valid}, 8'd0);
        end
        sendFrame(8'hAF, 8'hAA, 8'h01, 1'b1);
        drainFrame("lock", 8'h01, 1'b0);
        checkOutput("lock.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        sendFrame(8'hBA, 8'h55, 8'h20, 1'b1);
        drainFrame("hdrB", 8'h20, 1'b1);
        checkOutput("hdrB.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Backpressure: two frames held, the third dropped for lack of a slot.
        m_ready = 1'b0;
        sendFrame(8'hAF, 8'hAA, 8'h30, 1'b1);
        sendFrame(8'hAF, 8'hAA, 8'h40, 1'b1);
        sendFrame(8'hAF, 8'hAA, 8'h50, 1'b1);
        checkOutput("full", 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
        checkDrop("full", 8'd1);
        idleCycle();
        checkOutput("hold", 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
        m_ready = 1'b1;
        drainFrame("held0", 8'h30, 1'b0);
        drainFrame("held1", 8'h40, 1'b0);
        checkOutput("held.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Header lost mid-frame: positions 0,1,2,3,0 then the remaining positions never commit.
        applyStimulus(8'hAF, 4'd0, 1'b1);
        applyStimulus(8'h61, 4'd1, 1'b1);
        applyStimulus(8'h62, 4'd2, 1'b1);
        applyStimulus(8'h63, 4'd3, 1'b1);
        applyStimulus(8'h00, 4'd0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(8'h63 + 8'(i), 4'(i), 1'b1);
        end
        idleCycle();
        checkOutput("break", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkDrop("break", 8'd1);

        // Break on a valid header byte re-arms with the new header type.
        applyStimulus(8'hAF, 4'd0, 1'b1);
        applyStimulus(8'h71, 4'd1, 1'b1);
        applyStimulus(8'h72, 4'd2, 1'b1);
        applyStimulus(8'hBA, 4'd0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(8'h6F + 8'(i), 4'(i), 1'b1);
        end
        drainFrame("rearm", 8'h70, 1'b1);
        checkOutput("rearm.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Commit lands on the same edge as the last byte of the second held frame is read.
        m_ready = 1'b0;
        sendFrame(8'hAF, 8'hAA, 8'h80, 1'b1);
        sendFrame(8'hAF, 8'hAA, 8'h90, 1'b1);
        checkOutput("b2b.full", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idleCycle();
        end
        sendFrame(8'hAF, 8'hAA, 8'hA0, 1'b1);
        checkDrop("b2b", 8'd1);
        drainFrame("b2b", 8'hA0, 1'b0);
        checkOutput("b2b.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of capture: the partial frame must never appear.
        applyStimulus(8'hAA, 4'd11, 1'b1);
        applyStimulus(8'hAF, 4'd0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'hB0 + 8'(i), 4'(i), 1'b1);
        end
        reset = 1'b1;
        #2;
        checkOutput("rstcap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkDrop("rstcap", 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 6; i <= 10; i++) begin
            applyStimulus(8'hB0 + 8'(i), 4'(i), 1'b1);
        end
        idleCycle();
        checkOutput("rstcap.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a read discards the frame being delivered.
        m_ready = 1'b0;
        sendFrame(8'hAF, 8'hAA, 8'hC0, 1'b1);
        checkOutput("rstrd.commit", 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
        m_ready = 1'b1;
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("rstrd.mid", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        checkOutput("rstrd", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycle();
        checkOutput("rstrd.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkDrop("rstrd.after", 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
